hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Hazard and stall controller for the 5-stage pipelined MIPS core: produces `FlushE` and the stall enables consumed by the F/D, D/E, E/M and M/W pipeline registers, plus the forwarding selects for the D-stage branch comparator and the E-stage ALU. It combines combinational load-use and branch hazard detection with a sequential memory-wait FSM. The FSM freezes the whole pipeline while a data-memory access in M is outstanding, and halts the core on timeout.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: maximum number of WAIT cycles before the error halt.
- `TO_W`, default 8: wait-counter width; must satisfy `MEM_TIMEOUT < 2**TO_W`.

Ports (clock and reset first):
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `RsD`, `RtD` in 5 each: source registers in D.
- `RsE`, `RtE` in 5 each: source registers in E.
- `WriteRegE`, `WriteRegM`, `WriteRegW` in 5 each: destination registers in E, M and W.
- `RegWriteE`, `RegWriteM`, `RegWriteW` in 1 each: register-write enables in E, M and W.
- `MemtoRegE`, `MemtoRegM` in 1 each: the instruction in that stage is a load.
- `BranchD` in 1: the instruction in D is a branch.
- `MemReqM` in 1: the instruction in M accesses data memory.
- `MemReadyM` in 1: data memory has completed the access in this cycle.
- `PerfClr` in 1: synchronous clear of the performance counters.
- `StallF`, `StallD`, `StallE`, `StallM` out 1 each: hold the corresponding pipeline register.
- `FlushE` out 1: load a bubble into D/E.
- `FlushW` out 1: load a bubble into M/W.
- `ForwardAD`, `ForwardBD` out 1 each: forward the M-stage ALU result to the branch comparator.
- `ForwardAE`, `ForwardBE` out 2 each: ALU operand select. 00 = register file, 01 = W result, 10 = M result.
- `MemErr` out 1: sticky memory-timeout flag.
- `LoadStallCnt`, `BranchStallCnt`, `MemWaitCnt` out 32 each: performance counters.

## Operation
- In all hazard comparisons, register 0 never matches.
- Forwarding to E:
  - `ForwardAE = 10` if `RegWriteM` and `WriteRegM == RsE`.
  - Otherwise `ForwardAE = 01` if `RegWriteW` and `WriteRegW == RsE`.
  - Otherwise `ForwardAE = 00`.
  - `ForwardBE` is identical, using `RtE`.
- Forwarding to D: `ForwardAD = RegWriteM & (WriteRegM == RsD)`. `ForwardBD` is identical, using `RtD`.
- `lwstall = MemtoRegE & RegWriteE & (WriteRegE == RsD | WriteRegE == RtD)`.
- `brstall = BranchD & ((RegWriteE & WriteRegE ∈ {RsD, RtD}) | (MemtoRegM & WriteRegM ∈ {RsD, RtD}))`.
- `freeze` is asserted when any of the following holds:
  - the FSM is in IDLE and `MemReqM & !MemReadyM`;
  - the FSM is in WAIT and `!MemReadyM`;
  - the FSM is in ERR.
- When `freeze` is asserted: `StallF = StallD = StallE = StallM = 1`, `FlushW = 1`, `FlushE = 0`. Freeze overrides `lwstall` and `brstall`.
- When `freeze` is not asserted: `StallF = StallD = FlushE = lwstall | brstall`, and `StallE = StallM = FlushW = 0`.
- FSM states: IDLE, WAIT, ERR.
  - IDLE → WAIT when `MemReqM & !MemReadyM`; the wait counter loads 1.
  - WAIT → IDLE when `MemReadyM`; the counter clears.
  - WAIT → ERR when `!MemReadyM` and the counter equals `MEM_TIMEOUT`. `MemErr` sets to 1.
  - WAIT → WAIT otherwise; the counter increments.
  - ERR is terminal until `reset`.
- Simultaneous events: if `MemReadyM` arrives in the same cycle the counter reaches `MEM_TIMEOUT`, ready wins and the FSM returns to IDLE.

## Timing
- Forwarding selects, stalls and flushes are combinational from the inputs and the current FSM state, valid within the same cycle.
- A single-cycle memory access (`MemReadyM` together with `MemReqM`) causes zero stall cycles.
- An access that completes N cycles after `MemReqM` rises freezes the pipeline for exactly N cycles.
- On `reset` assertion, asynchronously:
  - FSM goes to IDLE, wait counter to 0, `MemErr = 0`, all performance counters to 0.
  - Combinational outputs then follow the inputs. With all inputs at 0, every output is 0.
- Reset asserted mid-WAIT or in ERR returns the FSM to IDLE immediately. Freeze releases in the same cycle unless `MemReqM & !MemReadyM` is still present.

## Configuration
- With `HAZARD_PERF_EN` defined: on each clock edge when `PerfClr` is 0, the counters update as follows:
  - `LoadStallCnt` increments when `lwstall & !freeze`.
  - `BranchStallCnt` increments when `brstall & !lwstall & !freeze`.
  - `MemWaitCnt` increments when `freeze`.
  - All three counters wrap modulo 2^32. `PerfClr` zeroes all three on the next edge and takes priority over incrementing.
- Without `HAZARD_PERF_EN`: no counter registers are built, the three count outputs are constant 0, and `PerfClr` is ignored.

## Test plan
- Load-use: `MemtoRegE = RegWriteE = 1`, `WriteRegE = 8`, `RsD = 8` → `StallF = StallD = FlushE = 1` for exactly one cycle; with `HAZARD_PERF_EN`, `LoadStallCnt` increments by 1.
- Forward priority: `WriteRegM = WriteRegW = 9`, both write enables 1, `RsE = 9` → `ForwardAE = 10`. Repeat with `RsE = 0` → `ForwardAE = 00`.
- Branch hazard: `BranchD = 1`, `RsD = 5`, `WriteRegE = 5`, `RegWriteE = 1` → stall and flush asserted. Next cycle, with the producer in M as a non-load, `ForwardAD = 1` and no stall.
- Memory wait: `MemReqM = 1`, `MemReadyM` rises on the 4th cycle → all stalls and `FlushW` asserted, `FlushE = 0`, for 3 cycles, then released; `MemWaitCnt = 3`.
- Timeout: `MEM_TIMEOUT = 4`, `MemReadyM` held at 0 → `MemErr = 1` after the 4th WAIT cycle, freeze persists, and asserting `reset` clears `MemErr` and the freeze asynchronously.
- Ready at limit: `MemReadyM` rises in the cycle the counter equals `MEM_TIMEOUT` → FSM returns to IDLE and `MemErr` stays 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: forwarding selects, load-use and branch stalls, and a
// memory-wait FSM that freezes the pipeline. Optional perf counters via HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  WriteRegE,
    input  logic [4:0]  WriteRegM,
    input  logic [4:0]  WriteRegW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        MemtoRegE,
    input  logic        MemtoRegM,
    input  logic        BranchD,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    input  logic        PerfClr,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushE,
    output logic        FlushW,
    output logic        ForwardAD,
    output logic        ForwardBD,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemErr,
    output logic [31:0] LoadStallCnt,
    output logic [31:0] BranchStallCnt,
    output logic [31:0] MemWaitCnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t          state, stateNext;
    logic [TO_W-1:0] waitCnt, waitCntNext;
    logic            memErr, memErrNext;
    logic            freeze;
    logic            lwstall;
    logic            brstall;

    // Register 0 is hard-wired zero, so it never creates a dependency.
    function automatic logic regMatch(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && regMatch(WriteRegM, RsE)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && regMatch(WriteRegW, RsE)) begin
            ForwardAE = 2'b01;
        end
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && regMatch(WriteRegM, RtE)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && regMatch(WriteRegW, RtE)) begin
            ForwardBE = 2'b01;
        end
    end

    assign ForwardAD = RegWriteM && regMatch(WriteRegM, RsD);
    assign ForwardBD = RegWriteM && regMatch(WriteRegM, RtD);

    assign lwstall = MemtoRegE && RegWriteE &&
                     (regMatch(WriteRegE, RsD) || regMatch(WriteRegE, RtD));

    assign brstall = BranchD &&
                     ((RegWriteE && (regMatch(WriteRegE, RsD) || regMatch(WriteRegE, RtD))) ||
                      (MemtoRegM && (regMatch(WriteRegM, RsD) || regMatch(WriteRegM, RtD))));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            waitCnt <= '0;
            memErr  <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            memErr  <= memErrNext;
        end
    end

    // Ready is checked before the timeout so a completion on the last allowed cycle is accepted.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        memErrNext  = memErr;
        case (state)
            S_IDLE: begin
                if (MemReqM && !MemReadyM) begin
                    stateNext   = S_WAIT;
                    waitCntNext = TO_W'(1);
                end
            end
            S_WAIT: begin
                if (MemReadyM) begin
                    stateNext   = S_IDLE;
                    waitCntNext = '0;
                end else if (waitCnt == TO_W'(MEM_TIMEOUT)) begin
                    stateNext  = S_ERR;
                    memErrNext = 1'b1;
                end else begin
                    waitCntNext = waitCnt + TO_W'(1);
                end
            end
            S_ERR: begin
                stateNext = S_ERR;
            end
            default: begin
                stateNext   = S_IDLE;
                waitCntNext = '0;
            end
        endcase
    end

    always_comb begin
        freeze = 1'b0;
        case (state)
            S_IDLE:  freeze = MemReqM && !MemReadyM;
            S_WAIT:  freeze = !MemReadyM;
            S_ERR:   freeze = 1'b1;
            default: freeze = 1'b0;
        endcase
        if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushE = 1'b0;
            FlushW = 1'b1;
        end else begin
            StallF = lwstall || brstall;
            StallD = lwstall || brstall;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushE = lwstall || brstall;
            FlushW = 1'b0;
        end
    end

    assign MemErr = memErr;

`ifdef HAZARD_PERF_EN
    logic [31:0] loadStallCnt;
    logic [31:0] branchStallCnt;
    logic [31:0] memWaitCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            loadStallCnt   <= '0;
            branchStallCnt <= '0;
            memWaitCnt     <= '0;
        end else if (PerfClr) begin
            loadStallCnt   <= '0;
            branchStallCnt <= '0;
            memWaitCnt     <= '0;
        end else begin
            if (lwstall && !freeze) begin
                loadStallCnt <= loadStallCnt + 32'd1;
            end
            if (brstall && !lwstall && !freeze) begin
                branchStallCnt <= branchStallCnt + 32'd1;
            end
            if (freeze) begin
                memWaitCnt <= memWaitCnt + 32'd1;
            end
        end
    end

    assign LoadStallCnt   = loadStallCnt;
    assign BranchStallCnt = branchStallCnt;
    assign MemWaitCnt     = memWaitCnt;
`else
    logic unusedPerfClr;
    assign unusedPerfClr  = PerfClr;
    assign LoadStallCnt   = 32'd0;
    assign BranchStallCnt = 32'd0;
    assign MemWaitCnt     = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT = 4); counter expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic        BranchD, MemReqM, MemReadyM, PerfClr;
    logic        StallF, StallD, StallE, StallM, FlushE, FlushW;
    logic        ForwardAD, ForwardBD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemErr;
    logic [31:0] LoadStallCnt, BranchStallCnt, MemWaitCnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .reset(reset),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM), .PerfClr(PerfClr),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr),
        .LoadStallCnt(LoadStallCnt), .BranchStallCnt(BranchStallCnt), .MemWaitCnt(MemWaitCnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
        MemReqM = 0; MemReadyM = 0; PerfClr = 0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkFreeze(input string tag, input logic exp);
        check({tag, "_StallF"}, {31'd0, StallF}, {31'd0, exp});
        check({tag, "_StallE"}, {31'd0, StallE}, {31'd0, exp});
        check({tag, "_StallM"}, {31'd0, StallM}, {31'd0, exp});
        check({tag, "_FlushW"}, {31'd0, FlushW}, {31'd0, exp});
        check({tag, "_FlushE"}, {31'd0, FlushE}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        clearInputs();
        #2;
        // Reset with all inputs low: every output is zero.
        check("rst_StallF", {31'd0, StallF}, 32'd0);
        check("rst_StallM", {31'd0, StallM}, 32'd0);
        check("rst_FlushE", {31'd0, FlushE}, 32'd0);
        check("rst_FlushW", {31'd0, FlushW}, 32'd0);
        check("rst_FwdAE", {30'd0, ForwardAE}, 32'd0);
        check("rst_FwdAD", {31'd0, ForwardAD}, 32'd0);
        check("rst_MemErr", {31'd0, MemErr}, 32'd0);
        check("rst_MemWaitCnt", MemWaitCnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        nextCycle();

        // Forwarding priority and register-0 exclusion.
        WriteRegM = 9; WriteRegW = 9; RegWriteM = 1; RegWriteW = 1; RsE = 9; RtE = 0;
        #1 check("fwd_AE_M", {30'd0, ForwardAE}, 32'd2);
        check("fwd_BE_r0", {30'd0, ForwardBE}, 32'd0);
        RsE = 0;
        #1 check("fwd_AE_r0", {30'd0, ForwardAE}, 32'd0);
        RsE = 9; RtE = 9; RegWriteM = 0;
        #1 check("fwd_AE_W", {30'd0, ForwardAE}, 32'd1);
        check("fwd_BE_W", {30'd0, ForwardBE}, 32'd1);
        RegWriteM = 1; RsD = 9; RtD = 4;
        #1 check("fwd_AD", {31'd0, ForwardAD}, 32'd1);
        check("fwd_BD", {31'd0, ForwardBD}, 32'd0);
        clearInputs();
        nextCycle();

        // Load-use on RsD for one cycle.
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RsD = 8;
        #1 check("lw_StallF", {31'd0, StallF}, 32'd1);
        check("lw_StallD", {31'd0, StallD}, 32'd1);
        check("lw_FlushE", {31'd0, FlushE}, 32'd1);
        check("lw_StallE", {31'd0, StallE}, 32'd0);
        nextCycle();
        MemtoRegE = 0; RegWriteE = 0; WriteRegE = 0;
        MemtoRegM = 1; RegWriteM = 1; WriteRegM = 8;
        #1 check("lw_release", {31'd0, StallF}, 32'd0);
        check("lw_cnt", LoadStallCnt, PERF ? 32'd1 : 32'd0);
        clearInputs();
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RtD = 8; RsD = 3;
        #1 check("lw_Rt", {31'd0, StallD}, 32'd1);
        WriteRegE = 0; RtD = 0; RsD = 0;
        #1 check("lw_r0", {31'd0, StallD}, 32'd0);
        clearInputs();
        nextCycle();

        // Branch hazard, then producer moves to M as a non-load.
        BranchD = 1; RsD = 5; WriteRegE = 5; RegWriteE = 1;
        #1 check("br_StallF", {31'd0, StallF}, 32'd1);
        check("br_FlushE", {31'd0, FlushE}, 32'd1);
        nextCycle();
        RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 5;
        #1 check("br_fwdAD", {31'd0, ForwardAD}, 32'd1);
        check("br_nostall", {31'd0, StallD}, 32'd0);
        check("br_cnt", BranchStallCnt, PERF ? 32'd1 : 32'd0);
        MemtoRegM = 1;
        #1 check("br_loadM", {31'd0, StallD}, 32'd1);
        clearInputs();
        // Load-use and branch together count only as a load stall.
        BranchD = 1; MemtoRegE = 1; RegWriteE = 1; WriteRegE = 7; RsD = 7;
        nextCycle();
        clearInputs();
        #1 check("both_lwcnt", LoadStallCnt, PERF ? 32'd2 : 32'd0);
        check("both_brcnt", BranchStallCnt, PERF ? 32'd1 : 32'd0);

        // Memory wait: ready on the 4th cycle, load-use present but overridden.
        MemReqM = 1; MemtoRegE = 1; RegWriteE = 1; WriteRegE = 8; RsD = 8;
        #1 checkFreeze("mw_c1", 1'b1);
        nextCycle();
        checkFreeze("mw_c2", 1'b1);
        nextCycle();
        checkFreeze("mw_c3", 1'b1);
        nextCycle();
        MemtoRegE = 0; RegWriteE = 0; WriteRegE = 0; RsD = 0; MemReadyM = 1;
        #1 checkFreeze("mw_c4", 1'b0);
        nextCycle();
        MemReqM = 0; MemReadyM = 0;
        #1 check("mw_cnt", MemWaitCnt, PERF ? 32'd3 : 32'd0);
        check("mw_lwcnt", LoadStallCnt, PERF ? 32'd2 : 32'd0);
        MemReqM = 1; MemReadyM = 1;
        #1 checkFreeze("mw_single", 1'b0);
        nextCycle();
        clearInputs();

        // Ready arrives exactly when the wait counter hits the limit.
        MemReqM = 1;
        nextCycle();
        for (int i = 0; i < 3; i++) nextCycle();
        MemReadyM = 1;
        #1 check("lim_nofreeze", {31'd0, StallM}, 32'd0);
        nextCycle();
        MemReqM = 0; MemReadyM = 0;
        #1 check("lim_idle", {31'd0, StallM}, 32'd0);
        check("lim_MemErr", {31'd0, MemErr}, 32'd0);
        check("lim_cnt", MemWaitCnt, PERF ? 32'd7 : 32'd0);

        // Timeout into ERR.
        MemReqM = 1;
        nextCycle();
        for (int i = 0; i < 3; i++) nextCycle();
        check("to_preErr", {31'd0, MemErr}, 32'd0);
        nextCycle();
        check("to_MemErr", {31'd0, MemErr}, 32'd1);
        MemReqM = 0; MemReadyM = 1;
        #1 checkFreeze("to_err", 1'b1);
        nextCycle();
        check("to_sticky", {31'd0, MemErr}, 32'd1);
        check("to_cnt", MemWaitCnt, PERF ? 32'd13 : 32'd0);
        // Asynchronous reset mid-cycle clears ERR and the freeze.
        #2 reset = 1'b1;
        #1 check("arst_MemErr", {31'd0, MemErr}, 32'd0);
        checkFreeze("arst", 1'b0);
        check("arst_cnt", MemWaitCnt, 32'd0);
        MemReqM = 1; MemReadyM = 0;
        #1 check("arst_req", {31'd0, StallM}, 32'd1);
        clearInputs();
        @(negedge clk);
        reset = 1'b0;
        nextCycle();

        // PerfClr takes priority over an active increment.
        MemReqM = 1;
        nextCycle();
        check("clr_pre", MemWaitCnt, PERF ? 32'd1 : 32'd0);
        PerfClr = 1;
        nextCycle();
        PerfClr = 0; MemReqM = 0; MemReadyM = 1;
        #1 check("clr_cnt", MemWaitCnt, 32'd0);
        nextCycle();
        clearInputs();
        #1 check("clr_idle", {31'd0, StallM}, 32'd0);
        check("clr_after", MemWaitCnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
